cmp_seq: RTL and testbench

- Sequential wide-operand comparator controller.
- Compares two N*W-bit operands one W-bit word per cycle, most-significant word first, using one shared W-bit cmp instance.
- Request and response sides use valid/ready handshakes; optional early exit on the first unequal word.
- Sits between issue logic and wide-compare consumers (branch resolve, sort/min-max units) that cannot afford an N*W-bit comparator.

---
 rtl/cmp_seq_pkg.sv | 24 ++
 rtl/cmp_seq_cmp.sv | 25 ++
 rtl/cmp_seq.sv | 153 +++++++++++++++
 tb/tb_cmp_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_seq_pkg.sv
// Shared types and helpers for the sequential wide-operand comparator.
package cmp_seq_pkg;

    // Controller states: accept a request, walk the words, hold the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // One-hot-while-valid comparison outcome.
    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } result_t;

    // Width of the word index counter; never narrower than one bit so that
    // a single-word configuration still has a legal counter.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_seq_cmp.sv
// Single-word magnitude comparator shared by the sequential controller.
module cmp_seq_cmp #(
    parameter int W         = 32,
    parameter int IS_SIGNED = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    assign eq = (a == b);

    generate
        if (IS_SIGNED != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
            assign lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
            assign lt = a < b;
        end
    endgenerate

endmodule

// File: rtl/cmp_seq.sv
// Sequential N*W-bit comparator: walks the operands one word per cycle,
// most-significant word first, through a single signed W-bit comparator.
module cmp_seq
    import cmp_seq_pkg::*;
#(
    parameter int W          = 32,
    parameter int N          = 4,
    parameter int IS_SIGNED  = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           i_req_vld,
    input  logic [N*W-1:0] i_req_a,
    input  logic [N*W-1:0] i_req_b,
    output logic           o_req_rdy,
    output logic           o_rsp_vld,
    output logic           o_rsp_eq,
    output logic           o_rsp_gt,
    output logic           o_rsp_lt,
    input  logic           i_rsp_rdy,
    output logic           o_busy
);

    localparam int            IW       = idx_w(N);
    localparam logic [IW-1:0] TOP_IDX  = IW'(N - 1);
    localparam logic [W-1:0]  MSB_MASK = W'(1) << (W - 1);

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic [N*W-1:0] a_reg, a_next;
    logic [N*W-1:0] b_reg, b_next;
    result_t        res_reg, res_next;
    result_t        hit_res_reg, hit_res_next;
    logic           hit_reg, hit_next;

    logic [W-1:0]   a_words [N];
    logic [W-1:0]   b_words [N];
    logic [W-1:0]   a_sel, b_sel;
    logic [W-1:0]   cmp_a, cmp_b;
    logic           flip_msb;
    logic           c_eq, c_gt, c_lt;
    result_t        word_res;
    result_t        final_res;
    logic           word_done;

    // Split the latched operands into addressable words.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_words
            assign a_words[gi] = a_reg[gi*W +: W];
            assign b_words[gi] = b_reg[gi*W +: W];
        end
    endgenerate

    assign a_sel = a_words[idx_reg];
    assign b_sel = b_words[idx_reg];

    // The shared comparator is signed. Only the top word of a signed operand
    // carries a sign; every other word is a plain magnitude, so its MSB is
    // flipped on both sides to turn the signed compare into an unsigned one.
    assign flip_msb = !((IS_SIGNED != 0) && (idx_reg == TOP_IDX));
    assign cmp_a    = flip_msb ? (a_sel ^ MSB_MASK) : a_sel;
    assign cmp_b    = flip_msb ? (b_sel ^ MSB_MASK) : b_sel;

    cmp_seq_cmp #(
        .W         (W),
        .IS_SIGNED (1)
    ) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .eq (c_eq),
        .gt (c_gt),
        .lt (c_lt)
    );

    assign word_res  = {c_eq, c_gt, c_lt};
    // Once a higher word has decided, lower words can no longer change it.
    assign final_res = hit_reg ? hit_res_reg : word_res;
    assign word_done = ((EARLY_EXIT != 0) && !c_eq) || (idx_reg == '0);

    // Next-state and datapath update for the request/compare/response walk.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        res_next     = res_reg;
        hit_next     = hit_reg;
        hit_res_next = hit_res_reg;
        unique case (state_reg)
            IDLE: begin
                if (i_req_vld) begin
                    a_next     = i_req_a;
                    b_next     = i_req_b;
                    idx_next   = TOP_IDX;
                    hit_next   = 1'b0;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (word_done) begin
                    res_next   = final_res;
                    hit_next   = 1'b0;
                    state_next = RSP;
                end else begin
                    idx_next = idx_reg - IW'(1);
                    if (!hit_reg && !c_eq) begin
                        hit_next     = 1'b1;
                        hit_res_next = word_res;
                    end
                end
            end
            RSP: begin
                if (i_rsp_rdy) begin
                    res_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            hit_reg     <= 1'b0;
            hit_res_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            res_reg     <= res_next;
            hit_reg     <= hit_next;
            hit_res_reg <= hit_res_next;
        end
    end

    assign o_req_rdy = (state_reg == IDLE);
    assign o_rsp_vld = (state_reg == RSP);
    assign o_busy    = (state_reg != IDLE);
    assign o_rsp_eq  = res_reg.eq;
    assign o_rsp_gt  = res_reg.gt;
    assign o_rsp_lt  = res_reg.lt;

endmodule

// File: tb/tb_cmp_seq.sv
// Scoreboard bench for cmp_seq: four instances cover every combination of
// IS_SIGNED and EARLY_EXIT with W=8, N=4.
module tb_cmp_seq;

    localparam int W = 8;
    localparam int N = 4;
    localparam int NDIR = 6;
    localparam logic [31:0] DIR_A [NDIR] = '{32'h12345678, 32'h80000000, 32'h00FF0000,
                                             32'hFFFFFFFF, 32'h12345679, 32'h13000000};
    localparam logic [31:0] DIR_B [NDIR] = '{32'h12345678, 32'h7FFFFFFF, 32'h00010000,
                                             32'h00000001, 32'h12345678, 32'h12FFFFFF};

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   lat;
        int   acc;
    } exp_t;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    int   cyc  = 0;
    int   n_run  = 0;
    int   n_fail = 0;
    bit   phase2 = 1'b0;
    bit   phase3 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int cfg, input int act, input int req);
        n_run++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cfg=%0d got=%0h required=%0h", name, cfg, act, req);
        end
    endfunction

    // Expected outcome from whole-operand arithmetic; latency is one accept
    // cycle plus the number of words the controller has to look at.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input bit sgn, input bit early);
        exp_t e;
        int   k;
        bit   found;
        if (sgn) begin
            e.gt = $signed(a) > $signed(b);
            e.lt = $signed(a) < $signed(b);
        end else begin
            e.gt = a > b;
            e.lt = a < b;
        end
        e.eq  = (a == b);
        k     = N;
        found = 1'b0;
        if (early) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (!found && (a[i*W +: W] != b[i*W +: W])) begin
                    k     = N - i;
                    found = 1'b1;
                end
            end
        end
        e.lat = 1 + k;
        e.acc = 0;
        return e;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam bit SGN   = (gi % 2) == 1;
        localparam bit EARLY = (gi / 2) == 1;

        logic        req_vld = 1'b0;
        logic [31:0] req_a   = '0;
        logic [31:0] req_b   = '0;
        logic        rsp_rdy = 1'b0;
        logic        req_rdy, rsp_vld, eq, gt, lt, busy;
        int          bp_mode = 0;
        bit          done1   = 1'b0;
        bit          done3   = 1'b0;
        exp_t        exp_q[$];
        exp_t        e_mon;
        bit          in_rsp  = 1'b0;
        int          held    = 0;

        cmp_seq #(
            .W          (W),
            .N          (N),
            .IS_SIGNED  (gi % 2),
            .EARLY_EXIT (gi / 2)
        ) dut (
            .clk       (clk),
            .arst      (arst),
            .i_req_vld (req_vld),
            .i_req_a   (req_a),
            .i_req_b   (req_b),
            .o_req_rdy (req_rdy),
            .o_rsp_vld (rsp_vld),
            .o_rsp_eq  (eq),
            .o_rsp_gt  (gt),
            .o_rsp_lt  (lt),
            .i_rsp_rdy (rsp_rdy),
            .o_busy    (busy)
        );

        // Present one request and wait (bounded) for it to be taken.
        task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push);
            int   w;
            exp_t e;
            @(negedge clk);
            req_vld = 1'b1;
            req_a   = a;
            req_b   = b;
            w = 0;
            while (!req_rdy && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!req_rdy) begin
                n_run++;
                n_fail++;
                $display("FAIL accept_timeout cfg=%0d got=busy required=accept", gi);
                req_vld = 1'b0;
                return;
            end
            if (push) begin
                e     = ref_model(a, b, SGN, EARLY);
                e.acc = cyc;
                exp_q.push_back(e);
            end
            @(negedge clk);
            // Scramble the inputs: the DUT must have latched the operands.
            req_vld = 1'b0;
            req_a   = $urandom;
            req_b   = $urandom;
        endtask

        task automatic wait_idle();
            int w;
            w = 0;
            while ((exp_q.size() != 0 || busy) && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("drain_timeout", gi, int'(exp_q.size() != 0 || busy), 0);
        endtask

        // Response-side ready: random, or forced low/high for backpressure.
        initial begin
            forever begin
                @(posedge clk);
                #1;
                case (bp_mode)
                    1:       rsp_rdy = 1'b0;
                    2:       rsp_rdy = 1'b1;
                    default: rsp_rdy = ($urandom_range(0, 3) != 0);
                endcase
            end
        end

        // Monitor: pop an expectation for each new response, then hold it.
        initial begin
            forever begin
                @(negedge clk);
                if (rsp_vld) begin
                    if (!in_rsp) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_rsp", gi, 1, 0);
                        end else begin
                            e_mon = exp_q.pop_front();
                            check("flags", gi, int'({eq, gt, lt}), int'({e_mon.eq, e_mon.gt, e_mon.lt}));
                            check("latency", gi, cyc - e_mon.acc, e_mon.lat);
                        end
                        held   = int'({eq, gt, lt});
                        in_rsp = 1'b1;
                    end else begin
                        check("flags_stable", gi, int'({eq, gt, lt}), held);
                    end
                    if (rsp_rdy) in_rsp = 1'b0;
                end else begin
                    in_rsp = 1'b0;
                    check("idle_flags", gi, int'({eq, gt, lt}), 0);
                end
            end
        end

        // Reset must take effect without a clock edge.
        initial begin
            forever begin
                @(posedge arst);
                #1;
                check("rst_busy", gi, int'(busy), 0);
                check("rst_rsp_vld", gi, int'(rsp_vld), 0);
                check("rst_flags", gi, int'({eq, gt, lt}), 0);
                check("rst_req_rdy", gi, int'(req_rdy), 1);
            end
        end

        // Stimulus: directed cases, random cases, backpressure, reset abort.
        initial begin
            logic [31:0] a, b, m;
            int w;
            @(negedge arst);
            for (int i = 0; i < NDIR; i++) begin
                a = DIR_A[i];
                b = DIR_B[i];
                send(a, b, 1'b1);
            end
            for (int i = 0; i < 30; i++) begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = $urandom;
                    1: b = a;
                    2: begin
                        m = 32'hFFFFFFFF << (8 * (4 - $urandom_range(1, 3)));
                        b = (a & m) | ($urandom & ~m);
                    end
                    default: b = a ^ (32'h80 << (8 * $urandom_range(0, 3)));
                endcase
                send(a, b, 1'b1);
            end
            wait_idle();

            // Hold the response while a new request is pending.
            bp_mode = 1;
            send(32'h00FF0000, 32'h00010000, 1'b1);
            w = 0;
            while (!rsp_vld && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("bp_rsp_seen", gi, int'(rsp_vld), 1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                req_vld = 1'b1;
                req_a   = $urandom;
                req_b   = $urandom;
                check("bp_req_rdy", gi, int'(req_rdy), 0);
            end
            bp_mode = 2;
            send(32'h80000000, 32'h7FFFFFFF, 1'b1);
            bp_mode = 0;
            wait_idle();
            done1 = 1'b1;

            // Request that will be killed by reset part-way through.
            while (!phase2) @(negedge clk);
            send(32'h00000005, 32'h00000003, 1'b0);
            while (!phase3) @(negedge clk);
            send(32'h00000005, 32'h00000003, 1'b1);
            wait_idle();
            done3 = 1'b1;
        end
    end

    initial begin
        int w;
        #2 arst = 1'b1;
        #6 arst = 1'b0;

        w = 0;
        while (!(g_cfg[0].done1 && g_cfg[1].done1 && g_cfg[2].done1 && g_cfg[3].done1) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        check("phase1_timeout", 0, w, w < 5000 ? w : -1);

        // Release the abort request; it is accepted two edges later and sits
        // at word index 2 one edge after that.
        @(posedge clk);
        #1 phase2 = 1'b1;
        repeat (3) @(posedge clk);
        #2 arst = 1'b1;
        #2 arst = 1'b0;
        @(posedge clk);
        #1 phase3 = 1'b1;

        w = 0;
        while (!(g_cfg[0].done3 && g_cfg[1].done3 && g_cfg[2].done3 && g_cfg[3].done3) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        check("phase3_timeout", 0, w, w < 2000 ? w : -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
